istate_wr_arbiter: RTL and testbench
====================================

ISTATE_WR_ARBITER -- requirements
Module: istate_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64: width of register write data.
REQ-002 SHALL have parameter FENCE_CYCLES, default 2, legal range 0..15: register-write hold-off cycles after a privilege-level write.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports ex_valid in 1, ex_addr in 6, ex_data in DATA_W: execute-unit writeback request.
REQ-006 SHALL have port ex_ready  out  1  execute request accepted this cycle.
REQ-007 SHALL have ports ld_valid in 1, ld_addr in 6, ld_data in DATA_W: load-unit writeback request.
REQ-008 SHALL have port ld_ready  out  1  load request accepted this cycle.
REQ-009 SHALL have ports pl_valid in 1, pl_data in 4: privilege-level write request.
REQ-010 SHALL have port pl_ready  out  1  privilege-level request accepted this cycle.
REQ-011 SHALL have ports wr_en out 1, wr1_addr out 6, wr1_data out DATA_W: internal-state register write port.
REQ-012 SHALL have ports wr_pl_en out 1, wr_pl_data out 4: internal-state privilege-level write port.
REQ-013 SHALL have port illegal  out  1  one-cycle pulse: accepted request carried an illegal address.
REQ-014 SHALL have port busy  out  1  high while in FENCE.

Function
REQ-015 SHALL implement FSM states IDLE and FENCE.
REQ-016 In IDLE, SHALL accept at most one request per cycle: pl highest priority; ex vs ld round-robin.
REQ-017 Round-robin pointer SHALL flip to the other requester after each ex or ld acceptance; unchanged on pl acceptance.
REQ-018 Ready SHALL be combinational from valid, state and pointer; never asserted without matching valid; never in FENCE.
REQ-019 Requesters hold valid/addr/data stable until ready; arbiter samples them on the accepting edge.
REQ-020 Accepted ex/ld with addr in 1..3: wr_en=1, wr1_addr/wr1_data = sampled values for exactly one cycle, the cycle after acceptance.
REQ-021 Accepted ex/ld with addr 0 or >3: wr_en stays 0; illegal=1 for the cycle after acceptance.
REQ-022 Accepted pl: wr_pl_en=1, wr_pl_data=pl_data the cycle after acceptance; FSM enters FENCE that same cycle.
REQ-023 FENCE SHALL last exactly FENCE_CYCLES cycles, then IDLE; FENCE_CYCLES=0 bypasses FENCE (next cycle arbitrates normally).
REQ-024 wr_en and wr_pl_en SHALL never be high in the same cycle.
REQ-025 Outside the specified pulses, wr_en, wr_pl_en, illegal SHALL be 0; wr1_addr/wr1_data/wr_pl_data hold last value.
REQ-026 Back-to-back acceptances in IDLE SHALL yield back-to-back write pulses (throughput 1/cycle).

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, pointer to ex, fence counter 0, all outputs 0.
REQ-028 Reset during FENCE or with a pending write pulse SHALL abort it; no write issued after rst_n rises.
REQ-029 First acceptance possible in the first cycle with rst_n high.

Configuration
REQ-030 Macro ISTATE_ARB_PERF_EN defined: SHALL add outputs gnt_cnt_ex, gnt_cnt_ld, gnt_cnt_pl (32 bits each), incremented per acceptance, wrap at 2^32, cleared by reset.
REQ-031 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-032 ex_valid=ld_valid=1 continuously, addrs 1 and 2 -> grants alternate ex,ld,ex,ld from reset; wr_en high every cycle, wr1_addr 1,2,1,2.
REQ-033 pl_valid=1, pl_data=4'h3 with ex_valid=1 -> pl_ready first, wr_pl_en=1 data 3 next cycle, busy=1 for 2 cycles, ex_ready only after.
REQ-034 ex_valid=1 addr 0 then addr 5 -> ex_ready each, wr_en=0, illegal=1 one cycle after each.
REQ-035 rst_n pulled low mid-FENCE -> busy, outputs 0 immediately; after release, ex request granted first cycle.
REQ-036 FENCE_CYCLES=0, pl then ex valid -> wr_pl_en cycle N+1, wr_en cycle N+2.
REQ-037 With ISTATE_ARB_PERF_EN, 5 ex and 3 ld acceptances -> gnt_cnt_ex=5, gnt_cnt_ld=3, gnt_cnt_pl=0.

Source files
------------

// File: rtl/istate_wr_arbiter.sv
// rtl/istate_wr_arbiter.sv - Internal-state register / privilege-level write arbiter (optional ISTATE_ARB_PERF_EN grant counters)
module istate_wr_arbiter #(
    parameter int DATA_W       = 64,
    parameter int FENCE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [5:0]        ex_addr,
    input  logic [DATA_W-1:0] ex_data,
    output logic              ex_ready,
    input  logic              ld_valid,
    input  logic [5:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              pl_valid,
    input  logic [3:0]        pl_data,
    output logic              pl_ready,
    output logic              wr_en,
    output logic [5:0]        wr1_addr,
    output logic [DATA_W-1:0] wr1_data,
    output logic              wr_pl_en,
    output logic [3:0]        wr_pl_data,
    output logic              illegal,
    output logic              busy
`ifdef ISTATE_ARB_PERF_EN
    ,
    output logic [31:0]       gnt_cnt_ex,
    output logic [31:0]       gnt_cnt_ld,
    output logic [31:0]       gnt_cnt_pl
`endif
);

    typedef enum logic {IDLE, FENCE} state_t;

    // Counter is loaded with FENCE_CYCLES-1 so FENCE spans exactly FENCE_CYCLES cycles.
    localparam logic [3:0] FENCE_INIT = (FENCE_CYCLES == 0) ? 4'd0 : 4'(FENCE_CYCLES - 1);

    state_t            state;
    logic              rr_ptr;      // 0: ex has priority, 1: ld has priority
    logic [3:0]        fence_cnt;
    logic              in_idle;
    logic              rr_accept;
    logic [5:0]        acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic              acc_legal;

    assign in_idle  = rst_n && (state == IDLE);
    assign pl_ready = in_idle && pl_valid;
    assign ex_ready = in_idle && !pl_valid && ex_valid && (!ld_valid || !rr_ptr);
    assign ld_ready = in_idle && !pl_valid && ld_valid && (!ex_valid || rr_ptr);

    assign rr_accept = ex_ready || ld_ready;
    assign acc_addr  = ex_ready ? ex_addr : ld_addr;
    assign acc_data  = ex_ready ? ex_data : ld_data;
    assign acc_legal = (acc_addr != 6'd0) && (acc_addr <= 6'd3);
    assign busy      = (state == FENCE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            fence_cnt  <= 4'd0;
            wr_en      <= 1'b0;
            wr1_addr   <= 6'd0;
            wr1_data   <= '0;
            wr_pl_en   <= 1'b0;
            wr_pl_data <= 4'd0;
            illegal    <= 1'b0;
        end else begin
            wr_en    <= 1'b0;
            wr_pl_en <= 1'b0;
            illegal  <= 1'b0;
            if (rr_accept) begin
                rr_ptr <= ex_ready;
                if (acc_legal) begin
                    wr_en    <= 1'b1;
                    wr1_addr <= acc_addr;
                    wr1_data <= acc_data;
                end else begin
                    illegal <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (pl_ready) begin
                        wr_pl_en   <= 1'b1;
                        wr_pl_data <= pl_data;
                        if (FENCE_CYCLES != 0) begin
                            state     <= FENCE;
                            fence_cnt <= FENCE_INIT;
                        end
                    end
                end
                FENCE: begin
                    if (fence_cnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        fence_cnt <= fence_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ISTATE_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt_ex <= 32'd0;
            gnt_cnt_ld <= 32'd0;
            gnt_cnt_pl <= 32'd0;
        end else begin
            if (ex_ready) gnt_cnt_ex <= gnt_cnt_ex + 32'd1;
            if (ld_ready) gnt_cnt_ld <= gnt_cnt_ld + 32'd1;
            if (pl_ready) gnt_cnt_pl <= gnt_cnt_pl + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_istate_wr_arbiter.sv
// tb/tb_istate_wr_arbiter.sv - Directed vector bench for istate_wr_arbiter
module tb_istate_wr_arbiter;

    localparam logic [63:0] EX_TAG = 64'hE000_0000_0000_0000;
    localparam logic [63:0] LD_TAG = 64'hD000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 0, ld_valid = 0, pl_valid = 0;
    logic [5:0]  ex_addr = 0, ld_addr = 0;
    logic [63:0] ex_data, ld_data;
    logic [3:0]  pl_data = 0;
    logic        ex_ready, ld_ready, pl_ready, wr_en, wr_pl_en, illegal, busy;
    logic [5:0]  wr1_addr;
    logic [63:0] wr1_data;
    logic [3:0]  wr_pl_data;

    logic        z_ex_valid = 0, z_ld_valid = 0, z_pl_valid = 0;
    logic [5:0]  z_ex_addr = 0, z_ld_addr = 0;
    logic [63:0] z_ex_data, z_ld_data;
    logic [3:0]  z_pl_data = 0;
    logic        z_ex_ready, z_ld_ready, z_pl_ready, z_wr_en, z_wr_pl_en, z_illegal, z_busy;
    logic [5:0]  z_wr1_addr;
    logic [63:0] z_wr1_data;
    logic [3:0]  z_wr_pl_data;

`ifdef ISTATE_ARB_PERF_EN
    logic [31:0] gnt_cnt_ex, gnt_cnt_ld, gnt_cnt_pl;
    logic [31:0] z_gnt_cnt_ex, z_gnt_cnt_ld, z_gnt_cnt_pl;
`endif

    assign ex_data   = EX_TAG | {58'd0, ex_addr};
    assign ld_data   = LD_TAG | {58'd0, ld_addr};
    assign z_ex_data = EX_TAG | {58'd0, z_ex_addr};
    assign z_ld_data = LD_TAG | {58'd0, z_ld_addr};

    always #5 clk = ~clk;

    istate_wr_arbiter #(.DATA_W(64), .FENCE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_addr(ex_addr), .ex_data(ex_data), .ex_ready(ex_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .pl_valid(pl_valid), .pl_data(pl_data), .pl_ready(pl_ready),
        .wr_en(wr_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .wr_pl_en(wr_pl_en), .wr_pl_data(wr_pl_data), .illegal(illegal), .busy(busy)
`ifdef ISTATE_ARB_PERF_EN
        , .gnt_cnt_ex(gnt_cnt_ex), .gnt_cnt_ld(gnt_cnt_ld), .gnt_cnt_pl(gnt_cnt_pl)
`endif
    );

    istate_wr_arbiter #(.DATA_W(64), .FENCE_CYCLES(0)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(z_ex_valid), .ex_addr(z_ex_addr), .ex_data(z_ex_data), .ex_ready(z_ex_ready),
        .ld_valid(z_ld_valid), .ld_addr(z_ld_addr), .ld_data(z_ld_data), .ld_ready(z_ld_ready),
        .pl_valid(z_pl_valid), .pl_data(z_pl_data), .pl_ready(z_pl_ready),
        .wr_en(z_wr_en), .wr1_addr(z_wr1_addr), .wr1_data(z_wr1_data),
        .wr_pl_en(z_wr_pl_en), .wr_pl_data(z_wr_pl_data), .illegal(z_illegal), .busy(z_busy)
`ifdef ISTATE_ARB_PERF_EN
        , .gnt_cnt_ex(z_gnt_cnt_ex), .gnt_cnt_ld(z_gnt_cnt_ld), .gnt_cnt_pl(z_gnt_cnt_pl)
`endif
    );

    typedef struct {
        logic       exv;
        logic [5:0] exa;
        logic       ldv;
        logic [5:0] lda;
        logic       plv;
        logic [3:0] pld;
        logic       e_exr, e_ldr, e_plr;
        logic       e_wr;
        logic [5:0] e_addr;
        logic       e_src;
        logic       e_ill, e_plen;
        logic [3:0] e_pld;
        logic       e_busy;
    } vec_t;

    vec_t vecs[18];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(logic exv, logic [5:0] exa, logic ldv, logic [5:0] lda,
                                logic plv, logic [3:0] pld, logic exr, logic ldr, logic plr,
                                logic wr, logic [5:0] addr, logic src, logic ill, logic plen,
                                logic [3:0] plo, logic bsy);
        vec_t v;
        v.exv = exv; v.exa = exa; v.ldv = ldv; v.lda = lda; v.plv = plv; v.pld = pld;
        v.e_exr = exr; v.e_ldr = ldr; v.e_plr = plr; v.e_wr = wr; v.e_addr = addr;
        v.e_src = src; v.e_ill = ill; v.e_plen = plen; v.e_pld = plo; v.e_busy = bsy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic exv, input logic [5:0] exa, input logic ldv,
                         input logic [5:0] lda, input logic plv, input logic [3:0] pld);
        ex_valid = exv; ex_addr = exa; ld_valid = ldv; ld_addr = lda;
        pl_valid = plv; pl_data = pld;
    endtask

    initial begin
        // ex/ld alternation, illegal addresses, fence after pl, pointer kept across pl.
        vecs[0]  = mk(1,1,1,2,0,4'h0, 1,0,0, 1,1,0,0,0,4'h0,0);
        vecs[1]  = mk(1,1,1,2,0,4'h0, 0,1,0, 1,2,1,0,0,4'h0,0);
        vecs[2]  = mk(1,1,1,2,0,4'h0, 1,0,0, 1,1,0,0,0,4'h0,0);
        vecs[3]  = mk(1,1,1,2,0,4'h0, 0,1,0, 1,2,1,0,0,4'h0,0);
        vecs[4]  = mk(1,0,0,0,0,4'h0, 1,0,0, 0,2,1,1,0,4'h0,0);
        vecs[5]  = mk(1,5,0,0,0,4'h0, 1,0,0, 0,2,1,1,0,4'h0,0);
        vecs[6]  = mk(0,0,1,3,0,4'h0, 0,1,0, 1,3,1,0,0,4'h0,0);
        vecs[7]  = mk(0,0,0,0,0,4'h0, 0,0,0, 0,3,1,0,0,4'h0,0);
        vecs[8]  = mk(1,1,0,0,1,4'h3, 0,0,1, 0,3,1,0,1,4'h3,1);
        vecs[9]  = mk(1,1,0,0,0,4'h0, 0,0,0, 0,3,1,0,0,4'h3,1);
        vecs[10] = mk(1,1,0,0,0,4'h0, 0,0,0, 0,3,1,0,0,4'h3,0);
        vecs[11] = mk(1,1,0,0,0,4'h0, 1,0,0, 1,1,0,0,0,4'h3,0);
        vecs[12] = mk(0,0,1,2,1,4'hA, 0,0,1, 0,1,0,0,1,4'hA,1);
        vecs[13] = mk(0,0,1,2,0,4'h0, 0,0,0, 0,1,0,0,0,4'hA,1);
        vecs[14] = mk(1,3,1,2,0,4'h0, 0,0,0, 0,1,0,0,0,4'hA,0);
        vecs[15] = mk(1,3,1,2,0,4'h0, 0,1,0, 1,2,1,0,0,4'hA,0);
        vecs[16] = mk(1,3,1,2,0,4'h0, 1,0,0, 1,3,0,0,0,4'hA,0);
        vecs[17] = mk(0,0,0,0,0,4'h0, 0,0,0, 0,3,0,0,0,4'hA,0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_pl_en", wr_pl_en, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr1_addr", wr1_addr, 0);
        chk("rst_wr1_data", wr1_data, 0);
        chk("rst_wr_pl_data", wr_pl_data, 0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].exv, vecs[i].exa, vecs[i].ldv, vecs[i].lda, vecs[i].plv, vecs[i].pld);
            #1;
            chk($sformatf("v%0d_ex_ready", i), ex_ready, vecs[i].e_exr);
            chk($sformatf("v%0d_ld_ready", i), ld_ready, vecs[i].e_ldr);
            chk($sformatf("v%0d_pl_ready", i), pl_ready, vecs[i].e_plr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wr_en", i), wr_en, vecs[i].e_wr);
            chk($sformatf("v%0d_wr1_addr", i), wr1_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_wr1_data", i), wr1_data,
                (vecs[i].e_src ? LD_TAG : EX_TAG) | {58'd0, vecs[i].e_addr});
            chk($sformatf("v%0d_illegal", i), illegal, vecs[i].e_ill);
            chk($sformatf("v%0d_wr_pl_en", i), wr_pl_en, vecs[i].e_plen);
            chk($sformatf("v%0d_wr_pl_data", i), wr_pl_data, vecs[i].e_pld);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
        end

        // Reset asserted mid-FENCE while the wr_pl_en pulse is showing.
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 4'h5);
        @(posedge clk);
        #1;
        chk("mf_busy_before", busy, 1);
        chk("mf_wr_pl_en_before", wr_pl_en, 1);
        drive(1, 1, 1, 2, 0, 4'h0);
        rst_n = 1'b0;
        #1;
        chk("mf_busy_rst", busy, 0);
        chk("mf_wr_pl_en_rst", wr_pl_en, 0);
        chk("mf_wr_pl_data_rst", wr_pl_data, 0);
        chk("mf_wr1_addr_rst", wr1_addr, 0);
        chk("mf_ex_ready_rst", ex_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mf_ex_ready_first", ex_ready, 1);
        chk("mf_ld_ready_first", ld_ready, 0);
        @(posedge clk);
        #1;
        chk("mf_wr_en_first", wr_en, 1);
        chk("mf_wr1_addr_first", wr1_addr, 1);
        chk("mf_wr_pl_en_after", wr_pl_en, 0);
        chk("mf_busy_after", busy, 0);

        // Back-to-back grants: ld,ex,ld,ex then ex,ex then ld -> totals ex 5, ld 3.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 4)      drive(1, 1, 1, 2, 0, 4'h0);
            else if (i < 6) drive(1, 1, 0, 0, 0, 4'h0);
            else            drive(0, 0, 1, 2, 0, 4'h0);
            @(posedge clk);
            #1;
            chk($sformatf("b2b%0d_wr_en", i), wr_en, 1);
            chk($sformatf("b2b%0d_wr1_addr", i), wr1_addr,
                (i == 6 || (i < 4 && i % 2 == 0)) ? 64'd2 : 64'd1);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 4'h0);
`ifdef ISTATE_ARB_PERF_EN
        #1;
        chk("perf_ex", gnt_cnt_ex, 5);
        chk("perf_ld", gnt_cnt_ld, 3);
        chk("perf_pl", gnt_cnt_pl, 0);
`endif

        // FENCE_CYCLES=0 instance: pl then ex on consecutive cycles.
        z_pl_valid = 1; z_pl_data = 4'h7; z_ex_valid = 1; z_ex_addr = 2;
        #1;
        chk("z_pl_ready", z_pl_ready, 1);
        chk("z_ex_ready_blocked", z_ex_ready, 0);
        @(posedge clk);
        #1;
        chk("z_wr_pl_en", z_wr_pl_en, 1);
        chk("z_wr_pl_data", z_wr_pl_data, 7);
        chk("z_wr_en_n1", z_wr_en, 0);
        chk("z_busy", z_busy, 0);
        @(negedge clk);
        z_pl_valid = 0;
        #1;
        chk("z_ex_ready", z_ex_ready, 1);
        @(posedge clk);
        #1;
        chk("z_wr_en_n2", z_wr_en, 1);
        chk("z_wr1_addr", z_wr1_addr, 2);
        chk("z_wr_pl_en_n2", z_wr_pl_en, 0);
        @(negedge clk);
        z_ex_valid = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
